// File: rtl/lsm_seq_pkg.sv
// lsm_seq_pkg: shared state and addressing-mode encodings for the load/store-multiple sequencer
package lsm_seq_pkg;
  typedef enum logic [1:0] {S_IDLE, S_XFER, S_FIN} state_t;
  typedef enum logic [1:0] {M_DA = 2'b00, M_IA = 2'b01, M_DB = 2'b10, M_IB = 2'b11} mode_t;
  function automatic mode_t mode_of(input logic p, input logic u);
    return mode_t'({p, u});
  endfunction
endpackage

// File: rtl/lsm_prio_enc.sv
// lsm_prio_enc: lowest-set-bit encoder giving the next register of a block transfer
module lsm_prio_enc #(
  parameter int N = 16,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         vld
);
  // scan downwards so the lowest set bit is the last one written
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) idx = req[i] ? W'(i) : idx;
  end
  assign vld = |req;
endmodule

// File: rtl/lsm_seq.sv
// lsm_seq: LDM/STM sequencer with IA/IB/DA/DB addressing and base writeback; LSM_ABORT_EN adds bus abort
module lsm_seq
  import lsm_seq_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int AW = 30,
  parameter int DW = 32,
  localparam int RW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_load,
  input  logic             p_bit,
  input  logic             u_bit,
  input  logic             w_bit,
  input  logic [RW-1:0]    rn,
  input  logic [AW-1:0]    base,
  input  logic [NREGS-1:0] reglist,
  output logic             busy,
  output logic             done,
  output logic             dstb,
  output logic             dwe,
  output logic [AW-1:0]    dadr,
  output logic [DW/8-1:0]  dsel,
  output logic [DW-1:0]    ddato,
  input  logic [DW-1:0]    ddati,
  input  logic             dack,
  output logic [RW-1:0]    rd_sel,
  input  logic [DW-1:0]    rd_data,
  output logic             wr_en,
  output logic [RW-1:0]    wr_sel,
  output logic [DW-1:0]    wr_data,
`ifdef LSM_ABORT_EN
  input  logic             dabt,
  output logic             abort,
`endif
  output logic             wb_en,
  output logic [AW-1:0]    wb_data
);
  localparam int CW = $clog2(NREGS + 1);
  state_t state, nxt;
  mode_t mode;
  logic ld, wbr, rn_hit, ab, kill, cur_v;
  logic [NREGS-1:0] rem, rem_nxt;
  logic [RW-1:0] cur;
  logic [AW-1:0] adr, wbv, n_aw, sa;
  logic [CW-1:0] n;
  lsm_prio_enc #(.N(NREGS)) u_enc (.req(rem), .idx(cur), .vld(cur_v));
`ifdef LSM_ABORT_EN
  assign kill = dack & dabt;
`else
  assign kill = 1'b0;
`endif
  // request decode: list size, lowest block address, and the list left after this beat
  always_comb begin
    n = '0;
    for (int i = 0; i < NREGS; i++) n = n + CW'(reglist[i]);
    n_aw = AW'(n);
    mode = mode_of(p_bit, u_bit);
    sa = mode == M_IA ? base : mode == M_IB ? base + 1'b1 : mode == M_DA ? base - n_aw + 1'b1 : base - n_aw;
    rem_nxt = rem & ~(NREGS'(1) << cur);
  end
  // state register
  always_ff @(posedge clk) state <= rst ? S_IDLE : nxt;
  // next state: empty lists skip straight to FIN; last beat or an abort closes XFER
  always_comb begin
    nxt = state == S_IDLE ? (start ? (|reglist ? S_XFER : S_FIN) : S_IDLE) :
          state == S_XFER ? (dack & (kill | ~|rem_nxt) ? S_FIN : S_XFER) : S_IDLE;
  end
  // request latch and per-beat bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      rem <= '0;
      adr <= '0;
      wbv <= '0;
      ld <= 1'b0;
      wbr <= 1'b0;
      rn_hit <= 1'b0;
      ab <= 1'b0;
    end else if (state == S_IDLE && start) begin
      rem <= reglist;
      adr <= sa;
      wbv <= u_bit ? base + n_aw : base - n_aw;
      ld <= is_load;
      wbr <= w_bit;
      rn_hit <= |(reglist & (NREGS'(1) << rn));
      ab <= 1'b0;
    end else if (state == S_XFER && dack) begin
      rem <= kill ? '0 : rem_nxt;
      adr <= adr + 1'b1;
      ab <= kill;
    end
  end
  // outputs: a loaded base register suppresses writeback
  always_comb begin
    busy = state != S_IDLE;
    done = state == S_FIN;
    dstb = state == S_XFER;
    dwe = ~ld;
    dadr = adr;
    dsel = '1;
    ddato = rd_data;
    rd_sel = cur;
    wr_en = dstb & cur_v & dack & ld & ~kill;
    wr_sel = cur;
    wr_data = ddati;
    wb_en = done & wbr & ~(ld & rn_hit) & ~ab;
    wb_data = wbv;
`ifdef LSM_ABORT_EN
    abort = done & ab;
`endif
  end
endmodule

// File: tb/tb_lsm_seq.sv
// tb_lsm_seq: scoreboard bench for lsm_seq with a block-transfer reference model; honours LSM_ABORT_EN
module tb_lsm_seq;
  typedef struct {
    bit fin;
    logic [29:0] adr;
    bit we;
    logic [31:0] dat;
    bit wr;
    logic [3:0] sel;
    logic [31:0] wdat;
    bit wb;
    logic [29:0] wbd;
    bit ab;
    int cyc;
  } exp_t;
  logic clk, rst, start, is_load, p_bit, u_bit, w_bit, dack;
  logic [3:0] rn, rd_sel, wr_sel;
  logic [29:0] base, dadr, wb_data;
  logic [15:0] reglist;
  logic busy, done, dstb, dwe, wr_en, wb_en;
  logic [3:0] dsel;
  logic [31:0] ddato, ddati, rd_data, wr_data;
`ifdef LSM_ABORT_EN
  logic dabt, abort;
`endif
  logic [31:0] regs [16];
  logic [31:0] salt;
  exp_t q[$];
  int nchk = 0, npass = 0, cyc = 0;
  int nw, wc, bi, abk;

  lsm_seq dut (
    .clk(clk), .rst(rst), .start(start), .is_load(is_load), .p_bit(p_bit), .u_bit(u_bit),
    .w_bit(w_bit), .rn(rn), .base(base), .reglist(reglist), .busy(busy), .done(done),
    .dstb(dstb), .dwe(dwe), .dadr(dadr), .dsel(dsel), .ddato(ddato), .ddati(ddati),
    .dack(dack), .rd_sel(rd_sel), .rd_data(rd_data), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_data(wr_data),
`ifdef LSM_ABORT_EN
    .dabt(dabt), .abort(abort),
`endif
    .wb_en(wb_en), .wb_data(wb_data)
  );

  function automatic logic [31:0] bus_word(logic [29:0] a);
    return {a, 2'b10} ^ salt;
  endfunction

  assign rd_data = regs[rd_sel];
  assign ddati = bus_word(dadr);

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    nchk++;
    if (act === req) npass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (dstb) begin
      if (nw < 0) dack = ($urandom % 3) == 0;
      else if (wc >= nw) begin
        dack = 1;
        wc = 0;
      end else begin
        dack = 0;
        wc++;
      end
    end else dack = 1'($urandom % 2);
`ifdef LSM_ABORT_EN
    dabt = dack ? (dstb && bi == abk) : 1'($urandom % 2);
`endif
    if (dstb && dack) bi++;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 200 && busy; t++) step();
    if (busy) chk("idle_timeout", busy, 0);
  endtask

  task automatic txn(bit l, bit p, bit u, bit w, logic [3:0] r, logic [29:0] b, logic [15:0] lst,
                     int nwi, int abi, bit lat);
    exp_t e;
    int n, k;
    bit abt;
    logic [29:0] lo;
    wait_idle();
    foreach (regs[i]) regs[i] = $urandom;
    salt = $urandom;
    n = $countones(lst);
    abt = abi >= 0 && abi < n;
    lo = u ? (p ? b + 30'd1 : b) : (p ? b - 30'(n) : b - 30'(n) + 30'd1);
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if (lst[i] && !(abt && k > abi)) begin
        e = '{default: 0};
        e.adr = lo + 30'(k);
        e.we = !l;
        e.dat = regs[i];
        e.wr = l && !(abt && k == abi);
        e.sel = 4'(i);
        e.wdat = bus_word(lo + 30'(k));
        q.push_back(e);
        k++;
      end
    end
    e = '{default: 0};
    e.fin = 1;
    e.wb = !abt && w && !(l && lst[r]);
    e.wbd = u ? b + 30'(n) : b - 30'(n);
    e.ab = abt;
    e.cyc = lat ? cyc + 1 + (abt ? abi + 1 : n) : -1;
    q.push_back(e);
    {is_load, p_bit, u_bit, w_bit, rn, base, reglist} = {l, p, u, w, r, b, lst};
    nw = nwi;
    wc = 0;
    bi = 0;
    abk = abt ? abi : -1;
    start = 1;
    step();
    start = 0;
    for (int t = 0; t < 400 && busy; t++) begin
      step();
      start = busy && ($urandom % 4 == 0);
      if (start) begin
        {is_load, p_bit, u_bit, w_bit, rn} = 8'($urandom);
        base = 30'($urandom);
        reglist = 16'($urandom);
      end
    end
    start = 0;
    if (busy) begin
      chk("txn_timeout", busy, 0);
      rst = 1;
      step();
      step();
      rst = 0;
      q.delete();
    end
  endtask

  // monitor: every completed beat and every done pulse consumes one expected record
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (dstb && dack) begin
        chk("beat_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("beat_kind", e.fin, 0);
          chk("dadr", dadr, e.adr);
          chk("dwe", dwe, e.we);
          chk("dsel", dsel, 4'hF);
          if (e.we) chk("ddato", ddato, e.dat);
          chk("wr_en", wr_en, e.wr);
          if (e.wr) begin
            chk("wr_sel", wr_sel, e.sel);
            chk("wr_data", wr_data, e.wdat);
          end
        end
      end else if (wr_en) chk("wr_en_outside_beat", wr_en, 0);
      if (done) begin
        chk("done_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("done_kind", e.fin, 1);
          chk("wb_en", wb_en, e.wb);
          chk("wb_data", wb_data, e.wbd);
`ifdef LSM_ABORT_EN
          chk("abort", abort, e.ab);
`endif
          if (e.cyc >= 0) chk("done_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    exp_t e;
    int abi;
    {start, is_load, p_bit, u_bit, w_bit, rn, base, reglist, dack} = '0;
`ifdef LSM_ABORT_EN
    dabt = 0;
`endif
    foreach (regs[i]) regs[i] = '0;
    salt = 0;
    nw = 0;
    wc = 0;
    bi = 0;
    abk = -1;
    rst = 1;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dstb", dstb, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wb_en", wb_en, 0);
`ifdef LSM_ABORT_EN
    chk("rst_abort", abort, 0);
`endif
    rst = 0;
    step();
    txn(0, 0, 1, 0, 4'd0, 30'h100, 16'h0005, 0, -1, 1);
    txn(1, 1, 0, 1, 4'd4, 30'h200, 16'h8003, 2, -1, 0);
    txn(1, 1, 1, 1, 4'd3, 30'h10, 16'h0008, 0, -1, 1);
    txn(0, 0, 1, 1, 4'd2, 30'h1234, 16'h0000, 0, -1, 1);
    txn(0, 1, 0, 1, 4'd0, 30'h1, 16'hF0F0, 0, -1, 1);
    wait_idle();
    salt = $urandom;
    e = '{default: 0};
    e.adr = 30'h40;
    e.wr = 1;
    e.wdat = bus_word(30'h40);
    q.push_back(e);
    {is_load, p_bit, u_bit, w_bit, rn, base, reglist} = {4'b1011, 4'd0, 30'h40, 16'h000F};
    nw = 0;
    wc = 0;
    bi = 0;
    abk = -1;
    start = 1;
    step();
    start = 0;
    step();
    rst = 1;
    dack = 0;
    step();
    chk("midrst_busy", busy, 0);
    chk("midrst_dstb", dstb, 0);
    chk("midrst_done", done, 0);
    chk("midrst_queue", q.size(), 0);
    rst = 0;
`ifdef LSM_ABORT_EN
    txn(1, 0, 1, 1, 4'd1, 30'h80, 16'h000F, 0, 1, 1);
`endif
    txn(1, 0, 1, 1, 4'd9, 30'h300, 16'h0201, 0, -1, 1);
    for (int t = 0; t < 60; t++) begin
      abi = -1;
`ifdef LSM_ABORT_EN
      if ($urandom % 4 == 0) abi = $urandom_range(0, 15);
`endif
      nw = ($urandom % 4 == 0) ? -1 : int'($urandom_range(0, 2));
      txn(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
          ($urandom % 3 == 0) ? 30'($urandom_range(0, 20)) : 30'($urandom),
          ($urandom % 6 == 0) ? 16'h0 : 16'($urandom & $urandom), nw, abi, nw == 0);
    end
    wait_idle();
    step();
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
